// File: rtl/decode_queue_if.sv
// decode_queue_if: RV32I control-word types plus the fetch/issue handshake bundle (in_*, out_*, count); slave modport for the queue, master for its driver
package rv32i_pkg;
  localparam logic [6:0] op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111,
                         op_jalr = 7'b1100111, op_br = 7'b1100011, op_load = 7'b0000011,
                         op_store = 7'b0100011, op_imm = 7'b0010011, op_reg = 7'b0110011,
                         op_csr = 7'b1110011;
  localparam logic [2:0] alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
                         alu_xor = 3'd4, alu_srl = 3'd5, alu_or = 3'd6, alu_and = 3'd7;
  localparam logic [2:0] f3_add = 3'd0, f3_sll = 3'd1, f3_slt = 3'd2, f3_sltu = 3'd3,
                         f3_sr = 3'd5;
  localparam logic [2:0] cmp_blt = 3'd4, cmp_bltu = 3'd6;
  localparam logic [1:0] pc_plus4 = 2'd0, pc_alu_out = 2'd1, pc_alu_mod2 = 2'd2;
  localparam logic alu1_rs1 = 1'b0, alu1_pc = 1'b1;
  localparam logic [2:0] alu2_i_imm = 3'd0, alu2_u_imm = 3'd1, alu2_b_imm = 3'd2,
                         alu2_s_imm = 3'd3, alu2_j_imm = 3'd4, alu2_rs2 = 3'd5;
  localparam logic cmp_rs2 = 1'b0, cmp_i_imm = 1'b1;
  localparam logic [2:0] rf_alu_out = 3'd0, rf_br_en = 3'd1, rf_u_imm = 3'd2,
                         rf_load = 3'd3, rf_pc_plus4 = 3'd4;
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic [2:0] regfilemux_sel;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
    logic       commit;
    logic       br_op;
    logic       jmp_op;
  } rv32i_ctrl_word;
endpackage

interface decode_queue_if #(parameter int DEPTH = 4);
  import rv32i_pkg::*;
  logic                         in_valid, in_ready, out_valid, out_ready;
  logic [31:0]                  in_pc, in_instr, out_pc, out_instr;
  rv32i_ctrl_word               out_ctrl;
  logic                         out_illegal, out_muldiv;
  logic [2:0]                   out_mdop;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport slave (input in_valid, in_pc, in_instr, out_ready,
                 output in_ready, out_valid, out_pc, out_instr, out_ctrl, out_illegal,
                 out_muldiv, out_mdop, count);
  modport master (output in_valid, in_pc, in_instr, out_ready,
                  input in_ready, out_valid, out_pc, out_instr, out_ctrl, out_illegal,
                  out_muldiv, out_mdop, count);
endinterface

// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode into a DEPTH-entry FIFO; ports clk, rst (sync high), flush, q (decode_queue_if.slave); RV32M_EN enables M-extension decode
module decode_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  decode_queue_if.slave  q
);
  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    rv32i_ctrl_word ctrl;
    logic           illegal;
    logic           muldiv;
    logic [2:0]     mdop;
  } entry_t;
  entry_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic           enq, deq, ill, md;
  logic [2:0]     mdop;
  rv32i_ctrl_word c;
  logic [6:0]     op, f7;
  logic [2:0]     f3;
  assign op = q.in_instr[6:0];
  assign f3 = q.in_instr[14:12];
  assign f7 = q.in_instr[31:25];
  always_comb begin
    c = '0;
    c.opcode = op;
    c.funct3 = f3;
    c.aluop = alu_add;
    c.pcmux_sel = pc_plus4;
    c.alumux1_sel = alu1_rs1;
    c.alumux2_sel = alu2_i_imm;
    c.cmpmux_sel = cmp_rs2;
    c.regfilemux_sel = rf_alu_out;
    ill = 1'b0;
    md = 1'b0;
    mdop = 3'd0;
    case (op)
      op_lui: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.alumux1_sel = alu1_pc;
        c.alumux2_sel = alu2_u_imm;
      end
      op_jal: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.jmp_op = 1'b1;
        c.alumux1_sel = alu1_pc;
        c.alumux2_sel = alu2_j_imm;
        c.pcmux_sel = pc_alu_out;
        c.regfilemux_sel = rf_pc_plus4;
      end
      op_jalr: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.jmp_op = 1'b1;
        c.pcmux_sel = pc_alu_mod2;
        c.regfilemux_sel = rf_pc_plus4;
        ill = f3 != 3'd0;
      end
      op_br: begin
        c.commit = 1'b1;
        c.br_op = 1'b1;
        c.cmpop = f3;
        c.alumux1_sel = alu1_pc;
        c.alumux2_sel = alu2_b_imm;
        ill = f3 == 3'b010 || f3 == 3'b011;
      end
      op_load: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.mem_read = 1'b1;
        c.regfilemux_sel = rf_load;
        ill = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
      end
      op_store: begin
        c.commit = 1'b1;
        c.mem_write = 1'b1;
        c.alumux2_sel = alu2_s_imm;
        ill = f3 > 3'b010;
      end
      op_imm: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        if (f3 == f3_slt || f3 == f3_sltu) begin
          c.cmpop = f3 == f3_slt ? cmp_blt : cmp_bltu;
          c.regfilemux_sel = rf_br_en;
          c.cmpmux_sel = cmp_i_imm;
        end else if (f3 == f3_sr) begin
          c.aluop = f7[5] ? alu_sra : alu_srl;
          ill = f7 != 7'b0000000 && f7 != 7'b0100000;
        end else begin
          c.aluop = f3;
          ill = f3 == f3_sll && f7 != 7'b0000000;
        end
      end
      op_reg: begin
        c.load_regfile = 1'b1;
        c.commit = 1'b1;
        c.alumux2_sel = alu2_rs2;
`ifdef RV32M_EN
        if (f7 == 7'b0000001) begin
          md = 1'b1;
          mdop = f3;
        end else
`endif
        begin
          if (f3 == f3_slt || f3 == f3_sltu) begin
            c.cmpop = f3 == f3_slt ? cmp_blt : cmp_bltu;
            c.regfilemux_sel = rf_br_en;
            c.cmpmux_sel = cmp_rs2;
          end else if (f3 == f3_add)
            c.aluop = f7[5] ? alu_sub : alu_add;
          else if (f3 == f3_sr)
            c.aluop = f7[5] ? alu_sra : alu_srl;
          else
            c.aluop = f3;
          ill = (f7 != 7'b0000000 && f7 != 7'b0100000) ||
                (f7 == 7'b0100000 && f3 != f3_add && f3 != f3_sr);
        end
      end
      default: ill = 1'b1;
    endcase
    if (q.in_instr[11:7] == 5'd0) c.load_regfile = 1'b0;
    if (ill) begin
      c.load_regfile = 1'b0;
      c.mem_read = 1'b0;
      c.mem_write = 1'b0;
      c.commit = 1'b0;
      c.br_op = 1'b0;
      c.jmp_op = 1'b0;
    end
  end
  assign q.in_ready = count != CNT_W'(DEPTH);
  assign q.out_valid = count != '0;
  assign q.count = count;
  assign enq = q.in_valid && q.in_ready && !flush && !rst;
  assign deq = q.out_valid && q.out_ready && !flush && !rst;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr, ctrl: c, illegal: ill, muldiv: md, mdop: mdop};
  assign q.out_pc = mem[rd_ptr].pc;
  assign q.out_instr = mem[rd_ptr].instr;
  assign q.out_ctrl = mem[rd_ptr].ctrl;
  assign q.out_illegal = mem[rd_ptr].illegal;
  assign q.out_muldiv = mem[rd_ptr].muldiv;
  assign q.out_mdop = mem[rd_ptr].mdop;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue (DEPTH 4), expected decode from a hand-written table
module tb_decode_queue;
  import rv32i_pkg::*;
  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;
  decode_queue_if #(.DEPTH(4)) bus();
  decode_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .flush(flush), .q(bus));
  typedef struct {
    logic [31:0] pc, instr;
    logic        ill, lr, cm, md;
    logic [2:0]  alu;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] addi(input int k);
    return 32'h00000093 | (32'(k) << 20);
  endfunction
  function automatic exp_t expect_of(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.ill = 1'b0;
    e.lr = 1'b1;
    e.cm = 1'b1;
    e.md = 1'b0;
    e.alu = 3'd0;
    case (instr)
      32'h40208033: begin e.lr = 1'b0; e.alu = 3'd3; end
      32'h4020D193: e.alu = 3'd2;
      32'h0020A423: e.lr = 1'b0;
      32'h0000000B, 32'h0000B003, 32'h00000073, 32'h0000A063: begin e.ill = 1'b1; e.lr = 1'b0; e.cm = 1'b0; end
`ifdef RV32M_EN
      32'h022081B3: e.md = 1'b1;
`else
      32'h022081B3: begin e.ill = 1'b1; e.lr = 1'b0; e.cm = 1'b0; end
`endif
      default: ;
    endcase
    return e;
  endfunction
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl = 1'b0, input logic rs = 1'b0);
    exp_t e;
    bus.in_valid = iv;
    bus.in_pc = pc;
    bus.in_instr = instr;
    bus.out_ready = ordy;
    flush = fl;
    rst = rs;
    #1;
    if (!fl && !rs && bus.out_valid && ordy) begin
      if (sb.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("out_instr", bus.out_instr, e.instr);
        check("illegal", 32'(bus.out_illegal), 32'(e.ill));
        check("load_regfile", 32'(bus.out_ctrl.load_regfile), 32'(e.lr));
        check("commit", 32'(bus.out_ctrl.commit), 32'(e.cm));
        check("aluop", 32'(bus.out_ctrl.aluop), 32'(e.alu));
        check("muldiv", 32'(bus.out_muldiv), 32'(e.md));
        check("opcode", 32'(bus.out_ctrl.opcode), 32'(e.instr[6:0]));
      end
    end
    if (!fl && !rs && iv && bus.in_ready) sb.push_back(expect_of(pc, instr));
    if (fl || rs) sb.delete();
    @(negedge clk);
    check("count", 32'(bus.count), 32'(sb.size()));
  endtask
  logic [31:0] mix [12] = '{32'h0000000B, 32'h40208033, 32'h022081B3, 32'h00208133,
                            32'h4020D193, 32'h00C0A103, 32'h0020A423, 32'h0000B003,
                            32'h00000073, 32'h0000A063, 32'h008000EF, 32'h0020A133};
  initial begin
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    step(1, 32'h60, 32'h00500093, 0);
    check("t1_out_valid", 32'(bus.out_valid), 1);
    check("t1_out_pc", bus.out_pc, 32'h60);
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), addi(i + 1), 0);
    check("full_count", 32'(bus.count), 4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    step(1, 32'h200, addi(9), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    check("drained_out_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) step(1, 32'h300 + 32'(4 * i), addi(i + 10), 0);
    for (int i = 0; i < 8; i++) step(1, 32'h340 + 32'(4 * i), addi(i + 20), 1);
    for (int i = 0; i < 10 && bus.out_valid; i++) step(0, 0, 0, 1);
    check("wrap_drained", 32'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) step(1, 32'h400 + 32'(4 * i), addi(i + 30), 0);
    check("pre_flush_count", 32'(bus.count), 3);
    step(1, 32'h480, addi(40), 1, 1);
    check("flush_out_valid", 32'(bus.out_valid), 0);
    check("flush_count", 32'(bus.count), 0);
    for (int i = 0; i < 12; i++) step(1, 32'h500 + 32'(4 * i), mix[i], i % 3 != 0);
    for (int i = 0; i < 10 && bus.out_valid; i++) step(0, 0, 0, 1);
    check("mix_drained", 32'(bus.out_valid), 0);
    step(1, 32'h600, addi(1), 0);
    step(1, 32'h604, addi(2), 0);
    step(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    check("rst_mid_count", 32'(bus.count), 0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 1);
    check("rst_mid_out_valid", 32'(bus.out_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
